// File: rtl/dmux_deserializer_8bit.sv
// rtl/dmux_deserializer_8bit.sv - bit-serial to byte deserializer; optional parity beat via DESER_PARITY_EN
module dmux_deserializer_8bit #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_perr,
  output logic [2:0] bit_idx
);

  logic [7:0] asm_q;
  logic [7:0] asm_next;
  logic [2:0] slot;
  logic       beat;
  logic       next_final;

`ifdef DESER_PARITY_EN
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } state_t;

  state_t state;

  // The parity beat is the one that completes a word.
  assign next_final = (state == ST_PARITY);
`else
  // Without parity the eighth data beat completes the word.
  assign next_final = (bit_idx == 3'd7);
  assign out_perr   = 1'b0;
`endif

  // DMUX select: slot the incoming bit according to the link bit order.
  assign slot = MSB_FIRST ? (3'd7 - bit_idx) : bit_idx;

  // Only a word-completing beat must wait for the held byte to drain.
  assign in_ready = !(next_final && out_valid && !out_ready);
  assign beat     = in_valid && in_ready;

  // Assembly register with the current bit steered into its slot.
  always_comb begin
    asm_next       = asm_q;
    asm_next[slot] = in_bit;
  end

  // Collect FSM plus output byte register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= 8'd0;
      bit_idx   <= 3'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
`ifdef DESER_PARITY_EN
      out_perr  <= 1'b0;
      state     <= ST_COLLECT;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr) begin
        asm_q   <= 8'd0;
        bit_idx <= 3'd0;
`ifdef DESER_PARITY_EN
        state   <= ST_COLLECT;
`endif
      end else if (beat) begin
`ifdef DESER_PARITY_EN
        case (state)
          ST_COLLECT: begin
            asm_q   <= asm_next;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            out_data  <= asm_q;
            out_perr  <= ^{asm_q, in_bit};
            out_valid <= 1'b1;
            asm_q     <= 8'd0;
            bit_idx   <= 3'd0;
            state     <= ST_COLLECT;
          end
        endcase
`else
        if (bit_idx == 3'd7) begin
          out_data  <= asm_next;
          out_valid <= 1'b1;
          asm_q     <= 8'd0;
          bit_idx   <= 3'd0;
        end else begin
          asm_q   <= asm_next;
          bit_idx <= bit_idx + 3'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_dmux_deserializer_8bit.sv
// tb/tb_dmux_deserializer_8bit.sv - self-checking bench for dmux_deserializer_8bit
module tb_dmux_deserializer_8bit;

`ifdef DESER_PARITY_EN
  localparam int W   = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int W   = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clr, in_bit, in_valid, out_ready;
  logic       in_ready0, out_valid0, out_perr0;
  logic       in_ready1, out_valid1, out_perr1;
  logic [7:0] out_data0, out_data1;
  logic [2:0] bit_idx0, bit_idx1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       perr;
  } exp_t;

  dmux_deserializer_8bit #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_perr(out_perr0), .bit_idx(bit_idx0)
  );

  dmux_deserializer_8bit #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_perr(out_perr1), .bit_idx(bit_idx1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  function automatic logic [15:0] word_bits(input logic [7:0] b, input logic p);
    return {7'd0, p, b};
  endfunction

  // Drive bits[0..n-1] back to back, each held until accepted.
  task automatic send_seq(input logic [15:0] bits, input int n);
    int waited;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      waited   = 0;
      @(negedge clk);
      while (!in_ready0 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready0) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout in_ready=%b required 1", in_ready0);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_data0 !== 8'h00) begin n_err++; $display("FAIL reset_data out_data=%h required 00", out_data0); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_valid out_valid=%b required 0", out_valid0); end
    n_cmp++; if (out_perr0 !== 1'b0) begin n_err++; $display("FAIL reset_perr out_perr=%b required 0", out_perr0); end
    n_cmp++; if (bit_idx0 !== 3'd0) begin n_err++; $display("FAIL reset_idx bit_idx=%0d required 0", bit_idx0); end
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_ready in_ready=%b required 1", in_ready0); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_seq(word_bits(8'h4D, ^8'h4D), W);
    @(negedge clk);
    n_cmp++; if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL basic_valid out_valid=%b required 1", out_valid0); end
    n_cmp++; if (out_data0 !== 8'h4D) begin n_err++; $display("FAIL basic_lsb_data out_data=%h required 4d", out_data0); end
    n_cmp++; if (out_data1 !== 8'hB2) begin n_err++; $display("FAIL basic_msb_data out_data=%h required b2", out_data1); end
    n_cmp++; if (bit_idx0 !== 3'd0) begin n_err++; $display("FAIL basic_idx bit_idx=%0d required 0", bit_idx0); end
    n_cmp++; if (out_perr0 !== 1'b0) begin n_err++; $display("FAIL basic_perr out_perr=%b required 0", out_perr0); end
    @(negedge clk);
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL basic_pulse out_valid=%b required 0", out_valid0); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] w2;
    w2 = word_bits(8'h3C, ^8'h3C);
    out_ready = 1'b0;
    send_seq(word_bits(8'hA5, ^8'hA5), W);
    send_seq(w2, W - 1);
    @(negedge clk);
    n_cmp++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL b2b_stall in_ready=%b required 0", in_ready0); end
    n_cmp++; if (bit_idx0 !== 3'((W - 1) % 8)) begin n_err++; $display("FAIL b2b_idx bit_idx=%0d required %0d", bit_idx0, (W - 1) % 8); end
    n_cmp++; if (out_data0 !== 8'hA5) begin n_err++; $display("FAIL b2b_first out_data=%h required a5", out_data0); end
    in_valid = 1'b1;
    in_bit   = w2[W-1];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_data0 !== 8'hA5 || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_hold data=%h valid=%b ready=%b required a5/1/0", out_data0, out_valid0, in_ready0);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL b2b_cont out_valid=%b required 1", out_valid0); end
    n_cmp++; if (out_data0 !== 8'h3C) begin n_err++; $display("FAIL b2b_second out_data=%h required 3c", out_data0); end
    n_cmp++; if (out_data1 !== rev8(8'h3C)) begin n_err++; $display("FAIL b2b_second_msb out_data=%h required %h", out_data1, rev8(8'h3C)); end
    @(negedge clk);
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL b2b_drain out_valid=%b required 0", out_valid0); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr;
    out_ready = 1'b1;
    send_seq(16'($urandom), 5);
    in_valid = 1'b1; in_bit = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bit_idx0 !== 3'd0) begin n_err++; $display("FAIL clr_idx bit_idx=%0d required 0", bit_idx0); end
    n_cmp++; if (out_data0 !== 8'h3C) begin n_err++; $display("FAIL clr_keep out_data=%h required 3c", out_data0); end
    @(posedge clk); #1;
    send_seq(word_bits(8'h6C, ^8'h6C), W);
    @(negedge clk);
    n_cmp++; if (out_data0 !== 8'h6C) begin n_err++; $display("FAIL clr_clean out_data=%h required 6c", out_data0); end
    n_cmp++; if (out_data1 !== 8'h36) begin n_err++; $display("FAIL clr_clean_msb out_data=%h required 36", out_data1); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send_seq(16'($urandom), 4);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_data0 !== 8'h00) begin n_err++; $display("FAIL rstmid_data out_data=%h required 00", out_data0); end
    n_cmp++; if (bit_idx0 !== 3'd0) begin n_err++; $display("FAIL rstmid_idx bit_idx=%0d required 0", bit_idx0); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL rstmid_valid out_valid=%b required 0", out_valid0); end
    @(posedge clk); #1 rst_n = 1'b1;
    send_seq(word_bits(8'h35, ^8'h35), W);
    @(negedge clk);
    n_cmp++; if (out_data0 !== 8'h35) begin n_err++; $display("FAIL rstmid_clean out_data=%h required 35", out_data0); end
    n_cmp++; if (out_data1 !== 8'hAC) begin n_err++; $display("FAIL rstmid_clean_msb out_data=%h required ac", out_data1); end
    @(posedge clk); #1;
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity;
    out_ready = 1'b1;
    send_seq(word_bits(8'h07, 1'b1), 8);
    @(negedge clk);
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL par_wait out_valid=%b required 0", out_valid0); end
    in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h07) begin n_err++; $display("FAIL par_byte valid=%b data=%h required 1/07", out_valid0, out_data0); end
    n_cmp++; if (out_perr0 !== 1'b0) begin n_err++; $display("FAIL par_good out_perr=%b required 0", out_perr0); end
    @(posedge clk); #1;
    send_seq(word_bits(8'h07, 1'b0), 9);
    @(negedge clk);
    n_cmp++; if (out_perr0 !== 1'b1) begin n_err++; $display("FAIL par_bad out_perr=%b required 1", out_perr0); end
    @(posedge clk); #1;
  endtask
`endif

  // Random traffic against a queue-based model of the word stream.
  task automatic test_random;
    exp_t       outq[$];
    logic       cur[$];
    exp_t       e;
    logic       ready;
    int         d0, d1, px;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      n_cmp++;
      if (out_valid0 !== (outq.size() != 0)) begin
        n_err++; $display("FAIL rand_valid cyc=%0d out_valid=%b required %b", c, out_valid0, outq.size() != 0);
      end
      if (outq.size() != 0) begin
        n_cmp++;
        if (out_data0 !== outq[0].d0 || out_data1 !== outq[0].d1 || out_perr0 !== outq[0].perr) begin
          n_err++;
          $display("FAIL rand_data cyc=%0d got %h/%h/%b required %h/%h/%b", c, out_data0, out_data1, out_perr0, outq[0].d0, outq[0].d1, outq[0].perr);
        end
      end
      n_cmp++;
      if (bit_idx0 !== 3'(cur.size() % 8)) begin
        n_err++; $display("FAIL rand_idx cyc=%0d bit_idx=%0d required %0d", c, bit_idx0, cur.size() % 8);
      end
      ready = !((cur.size() == W - 1) && (outq.size() != 0) && !out_ready);
      n_cmp++;
      if (in_ready0 !== ready) begin
        n_err++; $display("FAIL rand_ready cyc=%0d in_ready=%b required %b", c, in_ready0, ready);
      end
      if (outq.size() != 0 && out_ready) void'(outq.pop_front());
      if (clr) begin
        cur.delete();
      end else if (in_valid && ready) begin
        cur.push_back(in_bit);
        if (cur.size() == W) begin
          d0 = 0; d1 = 0; px = 0;
          for (int i = 0; i < W; i++) px = px + int'(cur[i]);
          for (int i = 0; i < 8; i++) begin
            d0 = d0 + (int'(cur[i]) << i);
            d1 = d1 + (int'(cur[i]) << (7 - i));
          end
          e.d0   = 8'(d0);
          e.d1   = 8'(d1);
          e.perr = PAR ? 1'(px % 2) : 1'b0;
          outq.push_back(e);
          cur.delete();
        end
      end
      @(posedge clk); #1;
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clr();
    test_reset_mid();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
